// File: rtl/sensor_tx_formatter.sv
// rtl/sensor_tx_formatter.sv - formats a tagged 16-bit sensor value as a 9-byte ASCII line into a Tx FIFO
module sensor_tx_formatter #(
    parameter int SUPPRESS_ZEROS = 0
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [7:0]  iTag,
    input  logic [15:0] iValue,
    input  logic        iTx_Full,
    output logic        oTx_Push,
    output logic [7:0]  oTx_Data,
    output logic        oBusy,
    output logic        oDone
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [7:0]  tagReg;
    logic [15:0] valueReg;
    logic [19:0] bcdReg;
    logic [3:0]  bitCnt;
    logic [3:0]  byteIdx;

    logic [15:0] bcdAdj;
    logic        nextBit;
    logic [3:0]  d4, d3, d2, d1, d0;
    logic        blank4, blank3, blank2, blank1;
    logic [7:0]  c4, c3, c2, c1, c0;
    logic [7:0]  msgByte;

    // Add-3 correction on the four low digits before each shift; the top digit
    // is never above 3 before the final shift of a 16-bit value, so it needs none.
    always_comb begin
        bcdAdj = bcdReg[15:0];
        for (int i = 0; i < 4; i++) begin
            if (bcdReg[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
            end
        end
    end

    // The captured value stays intact; the conversion walks it MSB first by index.
    assign nextBit = valueReg[4'd15 - bitCnt];

    assign d4 = bcdReg[19:16];
    assign d3 = bcdReg[15:12];
    assign d2 = bcdReg[11:8];
    assign d1 = bcdReg[7:4];
    assign d0 = bcdReg[3:0];

    // Leading-zero blanking chain; the units digit is always shown.
    always_comb begin
        blank4 = (SUPPRESS_ZEROS != 0) && (d4 == 4'd0);
        blank3 = blank4 && (d3 == 4'd0);
        blank2 = blank3 && (d2 == 4'd0);
        blank1 = blank2 && (d1 == 4'd0);
        c4 = blank4 ? 8'h20 : (8'h30 + {4'h0, d4});
        c3 = blank3 ? 8'h20 : (8'h30 + {4'h0, d3});
        c2 = blank2 ? 8'h20 : (8'h30 + {4'h0, d2});
        c1 = blank1 ? 8'h20 : (8'h30 + {4'h0, d1});
        c0 = 8'h30 + {4'h0, d0};
    end

    // Message byte selected by the current byte index.
    always_comb begin
        msgByte = 8'h00;
        case (byteIdx)
            4'd0:    msgByte = tagReg;
            4'd1:    msgByte = 8'h3A;
            4'd2:    msgByte = c4;
            4'd3:    msgByte = c3;
            4'd4:    msgByte = c2;
            4'd5:    msgByte = c1;
            4'd6:    msgByte = c0;
            4'd7:    msgByte = 8'h0D;
            4'd8:    msgByte = 8'h0A;
            default: msgByte = 8'h00;
        endcase
    end

    assign oTx_Push = (state == SEND) && !iTx_Full;
    assign oTx_Data = (state == SEND) ? msgByte : 8'h00;
    assign oBusy    = (state != IDLE);
    assign oDone    = (state == DONE);

    // Control FSM: capture, 16-step double dabble, flow-controlled send, done pulse.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            tagReg   <= 8'h00;
            valueReg <= 16'h0000;
            bcdReg   <= 20'h00000;
            bitCnt   <= 4'd0;
            byteIdx  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        tagReg   <= iTag;
                        valueReg <= iValue;
                        bcdReg   <= 20'h00000;
                        bitCnt   <= 4'd0;
                        byteIdx  <= 4'd0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcdReg <= {bcdReg[18:16], bcdAdj, nextBit};
                    bitCnt <= bitCnt + 4'd1;
                    if (bitCnt == 4'd15) begin
                        byteIdx <= 4'd0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (oTx_Push) begin
                        if (byteIdx == 4'd8) begin
                            state <= DONE;
                        end else begin
                            byteIdx <= byteIdx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_tx_formatter.sv
// tb/tb_sensor_tx_formatter.sv - directed self-checking bench for sensor_tx_formatter
module tb_sensor_tx_formatter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [7:0]  iTag;
    logic [15:0] iValue;
    logic        iTx_Full;

    logic        push0, busy0, done0;
    logic [7:0]  data0;
    logic        push1, busy1, done1;
    logic [7:0]  data1;

    always #5 iClk = ~iClk;

    sensor_tx_formatter #(.SUPPRESS_ZEROS(0)) dutPlain (
        .iClk     (iClk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iTag     (iTag),
        .iValue   (iValue),
        .iTx_Full (iTx_Full),
        .oTx_Push (push0),
        .oTx_Data (data0),
        .oBusy    (busy0),
        .oDone    (done0)
    );

    sensor_tx_formatter #(.SUPPRESS_ZEROS(1)) dutSupp (
        .iClk     (iClk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iTag     (iTag),
        .iValue   (iValue),
        .iTx_Full (iTx_Full),
        .oTx_Push (push1),
        .oTx_Data (data1),
        .oBusy    (busy1),
        .oDone    (done1)
    );

    int testCnt = 0;
    int failCnt = 0;

    logic [7:0] cap0 [0:15];
    logic [7:0] cap1 [0:15];
    int pushCyc [0:15];
    int pushCnt0, pushCnt1, doneCnt, doneCycle, busyCnt, lastBusy, holdOk;
    int rstPush, rstBusy, rstData;

    task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkMsg(input string tag, input logic [71:0] expMsg, input bit supp);
        for (int i = 0; i < 9; i++) begin
            checkEq($sformatf("%s byte%0d", tag, i), supp ? 32'(cap1[i]) : 32'(cap0[i]),
                    32'(expMsg[71-8*i -: 8]));
        end
        checkEq($sformatf("%s pushes", tag), supp ? pushCnt1 : pushCnt0, 9);
    endtask

    // One message: start at cycle 0, optional backpressure, restarts and reset, 45 cycles total.
    task automatic runMsg(input logic [7:0] tag, input logic [15:0] value, input int fullFrom,
                          input int fullLen, input int reStart1, input int reStart2, input int rstAt);
        pushCnt0 = 0; pushCnt1 = 0; doneCnt = 0; doneCycle = -1;
        busyCnt = 0; lastBusy = -1; holdOk = 0;
        rstPush = -1; rstBusy = -1; rstData = -1;
        for (int i = 0; i < 16; i++) begin
            cap0[i] = 8'h00; cap1[i] = 8'h00; pushCyc[i] = -1;
        end
        for (int c = 0; c < 45; c++) begin
            @(negedge iClk);
            iStart   = (c == 0) || (c == reStart1) || (c == reStart2);
            iTag     = (c == 0) ? tag : 8'h58;
            iValue   = (c == 0) ? value : 16'd999;
            iTx_Full = (c >= fullFrom) && (c < fullFrom + fullLen);
            if (c == rstAt) iRst = 1'b0;
            if (c == rstAt + 2) iRst = 1'b1;
            #1;
            if (push0) begin
                if (pushCnt0 < 16) begin
                    cap0[pushCnt0] = data0;
                    pushCyc[pushCnt0] = c;
                end
                pushCnt0++;
            end
            if (push1) begin
                if (pushCnt1 < 16) cap1[pushCnt1] = data1;
                pushCnt1++;
            end
            if (done0) begin
                doneCnt++;
                doneCycle = c;
            end
            if (busy0) begin
                busyCnt++;
                lastBusy = c;
            end
            if (iTx_Full && busy0 && !push0 && data0 == 8'h33) holdOk++;
            if (c == rstAt) begin
                rstPush = int'(push0);
                rstBusy = int'(busy0);
                rstData = int'(data0);
            end
        end
        iStart = 1'b0;
        iTx_Full = 1'b0;
    endtask

    initial begin
        iRst = 1'b0; iStart = 1'b0; iTag = 8'h00; iValue = 16'h0000; iTx_Full = 1'b0;
        repeat (2) @(negedge iClk);
        #1;
        checkEq("rst push", push0, 0);
        checkEq("rst busy", busy0, 0);
        checkEq("rst done", done0, 0);
        checkEq("rst data", data0, 0);
        checkEq("rst data supp", data1, 0);
        iRst = 1'b1;

        runMsg(8'h54, 16'd12345, -1, 0, -1, -1, -1);
        checkMsg("v12345", 72'h54_3A_31_32_33_34_35_0D_0A, 1'b0);
        checkMsg("v12345 supp", 72'h54_3A_31_32_33_34_35_0D_0A, 1'b1);
        checkEq("v12345 first push cyc", pushCyc[0], 17);
        checkEq("v12345 last push cyc", pushCyc[8], 25);
        checkEq("v12345 done cyc", doneCycle, 26);
        checkEq("v12345 done cnt", doneCnt, 1);

        runMsg(8'h54, 16'd65535, -1, 0, -1, -1, -1);
        checkMsg("v65535", 72'h54_3A_36_35_35_33_35_0D_0A, 1'b0);

        runMsg(8'h5A, 16'd0, -1, 0, -1, -1, -1);
        checkMsg("v0", 72'h5A_3A_30_30_30_30_30_0D_0A, 1'b0);
        checkMsg("v0 supp", 72'h5A_3A_20_20_20_20_30_0D_0A, 1'b1);

        runMsg(8'h54, 16'd407, -1, 0, -1, -1, -1);
        checkMsg("v407", 72'h54_3A_30_30_34_30_37_0D_0A, 1'b0);
        checkMsg("v407 supp", 72'h54_3A_20_20_34_30_37_0D_0A, 1'b1);

        runMsg(8'h54, 16'd12345, 21, 5, -1, -1, -1);
        checkMsg("full", 72'h54_3A_31_32_33_34_35_0D_0A, 1'b0);
        checkEq("full hold cycles", holdOk, 5);
        checkEq("full byte3 cyc", pushCyc[3], 20);
        checkEq("full resume cyc", pushCyc[4], 26);
        checkEq("full last push cyc", pushCyc[8], 30);
        checkEq("full done cyc", doneCycle, 31);

        runMsg(8'h54, 16'd12345, -1, 0, 5, 26, -1);
        checkMsg("restart", 72'h54_3A_31_32_33_34_35_0D_0A, 1'b0);
        checkEq("restart done cyc", doneCycle, 26);
        checkEq("restart done cnt", doneCnt, 1);
        checkEq("restart busy cycles", busyCnt, 26);
        checkEq("restart last busy", lastBusy, 26);

        runMsg(8'h54, 16'd12345, -1, 0, -1, -1, 21);
        checkEq("abort push", rstPush, 0);
        checkEq("abort busy", rstBusy, 0);
        checkEq("abort data", rstData, 0);
        checkEq("abort pushes", pushCnt0, 4);
        checkEq("abort done cnt", doneCnt, 0);
        checkEq("abort last busy", lastBusy, 20);

        runMsg(8'h41, 16'd54321, -1, 0, -1, -1, -1);
        checkMsg("after abort", 72'h41_3A_35_34_33_32_31_0D_0A, 1'b0);
        checkEq("after abort first cyc", pushCyc[0], 17);
        checkEq("after abort done cyc", doneCycle, 26);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/sensor_tx_formatter.md
SENSOR_TX_FORMATTER -- requirements
Module: sensor_tx_formatter

Interface
REQ-001 The block SHALL provide parameter SUPPRESS_ZEROS, default 0, meaning: when 1, leading zero digits are sent as space (0x20).
REQ-002 The block SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port iRst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port iStart, input, 1 bit: one-cycle request to format and send one message.
REQ-005 The block SHALL have port iTag, input, 8 bits: ASCII tag character heading the message.
REQ-006 The block SHALL have port iValue, input, 16 bits: unsigned sensor value.
REQ-007 The block SHALL have port iTx_Full, input, 1 bit: Tx FIFO full flag from the downstream UART FIFO stage.
REQ-008 The block SHALL have port oTx_Push, output, 1 bit: write strobe into the Tx FIFO, one byte per asserted cycle.
REQ-009 The block SHALL have port oTx_Data, output, 8 bits: byte written when oTx_Push is high.
REQ-010 The block SHALL have port oBusy, output, 1 bit: high whenever the block is not in IDLE.
REQ-011 The block SHALL have port oDone, output, 1 bit: one-cycle pulse after the last byte is pushed.

Function
REQ-012 The block SHALL implement the states IDLE, CONV, SEND and DONE.
REQ-013 In IDLE, when iStart is 1, the block SHALL capture iTag and iValue into internal registers, clear the digit register, and enter CONV on the next edge.
REQ-014 In states other than IDLE, iStart SHALL be ignored and the captured iTag/iValue SHALL stay unchanged.
REQ-015 In CONV, the block SHALL perform binary-to-BCD conversion by shift-add-3 (double dabble), one bit per cycle, MSB first, for exactly 16 cycles.
REQ-016 CONV SHALL produce 5 BCD digits d4..d0, covering 0..65535, with no overflow.
REQ-017 After the 16th CONV cycle, the block SHALL enter SEND with byte index 0.
REQ-018 The message SHALL be 9 bytes, in this order: tag, 0x3A (':'), d4..d0 as 0x30+digit, 0x0D, 0x0A.
REQ-019 When SUPPRESS_ZEROS=1, every zero digit before the first nonzero digit among d4..d1 SHALL be sent as 0x20; d0 SHALL always be sent as a numeral.
REQ-020 oTx_Push SHALL be combinational: (state==SEND) AND NOT iTx_Full.
REQ-021 oTx_Data SHALL be the message byte selected by the current byte index, valid and stable throughout SEND.
REQ-022 The byte index SHALL advance only on cycles where oTx_Push=1.
REQ-023 While iTx_Full=1, the block SHALL push nothing and hold the index and oTx_Data unchanged; there is no timeout.
REQ-024 When the push of byte index 8 occurs, the block SHALL enter DONE.
REQ-025 DONE SHALL last one cycle with oDone=1 and then return to IDLE; iStart during DONE SHALL be ignored.
REQ-026 Latency SHALL be as follows: with iStart at cycle 0 and iTx_Full=0, bytes are pushed on cycles 17..25, oDone=1 on cycle 26, and a new iStart is accepted from cycle 27.
REQ-027 oTx_Push SHALL be 0 in IDLE, CONV and DONE; no byte SHALL be pushed twice or skipped.

Reset
REQ-028 While iRst=0, the block SHALL asynchronously force the state to IDLE, the byte index to 0, and the captured tag, value and digit registers to 0.
REQ-029 During reset the outputs SHALL be oTx_Push=0, oBusy=0, oDone=0 and oTx_Data=0x00.
REQ-030 Reset asserted mid-CONV or mid-SEND SHALL abort the message immediately: no further pushes, and no oDone for the aborted message.
REQ-031 After iRst returns to 1, the block SHALL stay in IDLE until the next iStart.

Verification
REQ-032 The bench SHALL cover: SUPPRESS_ZEROS=0, iTag=0x54, iValue=12345, iTx_Full=0 -> pushes 54 3A 31 32 33 34 35 0D 0A on cycles 17..25, and oDone on cycle 26.
REQ-033 The bench SHALL cover: iValue=65535 -> digit bytes 36 35 35 33 35; iValue=0 -> digit bytes 30 30 30 30 30.
REQ-034 The bench SHALL cover: SUPPRESS_ZEROS=1, iValue=0 -> 20 20 20 20 30; iValue=407 -> 20 20 34 30 37.
REQ-035 The bench SHALL cover: iTx_Full held 1 for 5 cycles right after byte 0x32 is pushed -> no push and oTx_Data=0x33 held for those 5 cycles; then the message resumes with 0x33; exactly 9 pushes in total.
REQ-036 The bench SHALL cover: a second iStart with iValue=999 during CONV, and again during DONE -> ignored; the original message is unchanged and oBusy falls only after oDone.
REQ-037 The bench SHALL cover: iRst=0 asserted after 4 bytes are pushed -> oTx_Push=0 and oBusy=0 in the same cycle; after release, a new iStart sends a complete, correct 9-byte message.
